// File: rtl/clock_gate_array.sv
// clock_gate_array: per-channel latch-based clock gates with hold-off drain.
// Each channel runs an OFF/ON/DRAIN FSM that keeps its clock alive HOLD cycles.
module clock_gate_array #(
    parameter int NUM_CH = 4,
    parameter int HOLD   = 4
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            te,
    input  logic [NUM_CH-1:0]               en,
    input  logic [NUM_CH-1:0]               force_off,
    output logic [NUM_CH-1:0]               gclk,
    output logic [NUM_CH-1:0]               ch_on,
    output logic [$clog2(NUM_CH+1)-1:0]     num_on,
    output logic                            all_off
);

    localparam int NW = $clog2(NUM_CH + 1);
    localparam int CW = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
    localparam logic [CW-1:0] LOAD = CW'((HOLD > 0) ? HOLD - 1 : 0);

    typedef enum logic [1:0] {
        S_OFF,
        S_ON,
        S_DRAIN
    } state_t;

    state_t            state_q [NUM_CH];
    state_t            state_d [NUM_CH];
    logic [CW-1:0]     cnt_q   [NUM_CH];
    logic [CW-1:0]     cnt_d   [NUM_CH];
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] on_d;
    logic [NW-1:0]     num_d;
    logic [NUM_CH-1:0] ce;
    logic [NUM_CH-1:0] ce_lat;

    assign req = en & ~force_off;

    // Next-state logic for every channel; force_off beats any request.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (force_off[i]) begin
                state_d[i] = S_OFF;
                cnt_d[i]   = '0;
            end else begin
                unique case (state_q[i])
                    S_OFF: begin
                        if (req[i]) state_d[i] = S_ON;
                    end
                    S_ON: begin
                        if (!req[i]) begin
                            if (HOLD > 0) begin
                                state_d[i] = S_DRAIN;
                                cnt_d[i]   = LOAD;
                            end else begin
                                state_d[i] = S_OFF;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (req[i]) begin
                            state_d[i] = S_ON;
                            cnt_d[i]   = '0;
                        end else if (cnt_q[i] == '0) begin
                            state_d[i] = S_OFF;
                        end else begin
                            cnt_d[i] = cnt_q[i] - 1'b1;
                        end
                    end
                    default: begin
                        state_d[i] = S_OFF;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
        end
    end

    // Status derived from next state so it lines up with the FSM registers.
    always_comb begin
        num_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            on_d[i] = (state_d[i] != S_OFF);
            num_d   = num_d + NW'(on_d[i]);
        end
    end

    // FSM, counter and status registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= S_OFF;
                cnt_q[i]   <= '0;
            end
            ch_on   <= '0;
            num_on  <= '0;
            all_off <= 1'b1;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            ch_on   <= on_d;
            num_on  <= num_d;
            all_off <= (num_d == '0);
        end
    end

    // ch_on mirrors state != OFF, so it serves as the FSM part of the enable.
    assign ce = {NUM_CH{te}} | ch_on;

    // Enable latch: open while clock is low, closed while it is high.
    always_latch begin
        if (!reset_n) begin
            ce_lat <= '0;
        end else if (!clock) begin
            ce_lat <= ce;
        end
    end

    assign gclk = {NUM_CH{clock}} & ce_lat;

endmodule
